// File: rtl/k4n4_test_pkg.sv
// Shared types and golden model for the K4N4 gate benchmark checker.
// Bit order of a 6-bit gate word: {XOR,XNOR,AND,NAND,OR,NOR}.
package k4n4_test_pkg;

  localparam int IDX_XOR  = 5;
  localparam int IDX_XNOR = 4;
  localparam int IDX_AND  = 3;
  localparam int IDX_NAND = 2;
  localparam int IDX_OR   = 1;
  localparam int IDX_NOR  = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [5:0] exp_bits(input logic [2:0] v);
    logic [5:0] w;
    w           = '0;
    w[IDX_XOR]  = ^v;
    w[IDX_XNOR] = ~^v;
    w[IDX_AND]  = &v;
    w[IDX_NAND] = ~&v;
    w[IDX_OR]   = |v;
    w[IDX_NOR]  = ~|v;
    return w;
  endfunction

endpackage

// File: rtl/k4n4_test_checker_if.sv
// Stimulus/response bundle between the checker and the gate benchmark.
// The checker is master: it drives a/b/c and observes the gate words.
interface k4n4_test_checker_if;

  logic       a;
  logic       b;
  logic       c;
  logic [5:0] comb_i;
  logic [5:0] sync_i;

  modport master (
    output a, b, c,
    input  comb_i, sync_i
  );

  modport slave (
    input  a, b, c,
    output comb_i, sync_i
  );

endinterface

// File: rtl/k4n4_vec_cmp.sv
// Compares one observed gate word with the golden word of a vector.
// Purely combinational; the caller gates the result with its enable.
module k4n4_vec_cmp
  import k4n4_test_pkg::*;
(
  input  logic [5:0] obs,
  input  logic [2:0] vec,
  output logic       mismatch
);

  assign mismatch = (obs != exp_bits(vec));

endmodule

// File: rtl/k4n4_test_checker.sv
// K4N4 benchmark self-test: sweeps a/b/c and counts bad gate words.
// K4N4_CHECKER_FIRST_FAIL_EN adds capture of the first mismatch.
module k4n4_test_checker
  import k4n4_test_pkg::*;
#(
  parameter int PASSES    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  k4n4_test_checker_if.master  bif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           vec_idx,
  output logic                 first_fail_vld,
  output logic [2:0]           first_fail_vec,
  output logic                 first_fail_is_sync,
  output logic [5:0]           first_fail_bits
);

  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES - 1);

  state_t               state_q, state_d;
  logic [2:0]           vec_q, vec_d;
  logic [2:0]           prev_q, prev_d;
  logic [PC_W-1:0]      pcnt_q, pcnt_d;
  logic                 first_q, first_d;
  logic [ERR_CNT_W-1:0] err_q, err_d, err_sat;
  logic [ERR_CNT_W:0]   err_sum;
  logic                 comb_raw, sync_raw;
  logic                 comb_bad, sync_bad;
  logic                 start_ok;

  k4n4_vec_cmp u_cmp_comb (
    .obs      (bif.comb_i),
    .vec      (vec_q),
    .mismatch (comb_raw)
  );

  // Benchmark flops lag one cycle, so sync is judged against prev_q.
  k4n4_vec_cmp u_cmp_sync (
    .obs      (bif.sync_i),
    .vec      (prev_q),
    .mismatch (sync_raw)
  );

  assign comb_bad = (state_q == RUN) && comb_raw;
  assign sync_bad = ((state_q == RUN) && !first_q
                    || (state_q == FLUSH)) && sync_raw;
  assign start_ok = start
                  && ((state_q == IDLE) || (state_q == DONE));

  assign err_sum = {1'b0, err_q}
                 + (ERR_CNT_W+1)'(comb_bad)
                 + (ERR_CNT_W+1)'(sync_bad);
  assign err_sat = err_sum[ERR_CNT_W] ? '1
                 : err_sum[ERR_CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    prev_d  = prev_q;
    pcnt_d  = pcnt_q;
    first_d = first_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = RUN;
          vec_d   = '0;
          prev_d  = '0;
          pcnt_d  = '0;
          first_d = 1'b1;
          err_d   = '0;
        end
      end
      RUN: begin
        err_d   = err_sat;
        first_d = 1'b0;
        prev_d  = vec_q;
        if (vec_q == 3'd7) begin
          if (pcnt_q == LAST_PASS) begin
            state_d = FLUSH;
          end else begin
            vec_d  = '0;
            pcnt_d = pcnt_q + 1'b1;
          end
        end else begin
          vec_d = vec_q + 3'd1;
        end
      end
      FLUSH: begin
        err_d   = err_sat;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      prev_q  <= '0;
      pcnt_q  <= '0;
      first_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      prev_q  <= prev_d;
      pcnt_q  <= pcnt_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign bif.a   = vec_q[2];
  assign bif.b   = vec_q[1];
  assign bif.c   = vec_q[0];
  assign vec_idx = vec_q;
  assign err_cnt = err_q;
  assign busy    = (state_q == RUN) || (state_q == FLUSH);
  assign done    = (state_q == DONE);
  assign pass    = done && (err_q == '0);

`ifdef K4N4_CHECKER_FIRST_FAIL_EN
  logic       ff_vld_q;
  logic [2:0] ff_vec_q;
  logic       ff_sync_q;
  logic [5:0] ff_bits_q;

  // Comb takes priority when both checks fail in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      ff_vld_q  <= 1'b0;
      ff_vec_q  <= '0;
      ff_sync_q <= 1'b0;
      ff_bits_q <= '0;
    end else if (!ff_vld_q && comb_bad) begin
      ff_vld_q  <= 1'b1;
      ff_vec_q  <= vec_q;
      ff_sync_q <= 1'b0;
      ff_bits_q <= bif.comb_i;
    end else if (!ff_vld_q && sync_bad) begin
      ff_vld_q  <= 1'b1;
      ff_vec_q  <= prev_q;
      ff_sync_q <= 1'b1;
      ff_bits_q <= bif.sync_i;
    end
  end

  assign first_fail_vld     = ff_vld_q;
  assign first_fail_vec     = ff_vec_q;
  assign first_fail_is_sync = ff_sync_q;
  assign first_fail_bits    = ff_bits_q;
`else
  assign first_fail_vld     = 1'b0;
  assign first_fail_vec     = '0;
  assign first_fail_is_sync = 1'b0;
  assign first_fail_bits    = '0;
`endif

endmodule

// File: tb/tb_k4n4_test_checker.sv
// Bench for k4n4_test_checker: behavioural gate benchmark with fault
// injection, plus a sweep-level reference model of the expected result.
module tb_k4n4_test_checker;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  k4n4_test_checker_if bif ();
  k4n4_test_checker_if bif2 ();

  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [2:0] vec_idx;
  logic       ff_vld, ff_sync;
  logic [2:0] ff_vec;
  logic [5:0] ff_bits;

  logic       busy2, done2, pass2;
  logic [2:0] err2;
  logic [2:0] vec2;
  logic       ff_vld2, ff_sync2;
  logic [2:0] ff_vec2;
  logic [5:0] ff_bits2;

  k4n4_test_checker #(.PASSES(P), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bif(bif),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .vec_idx(vec_idx),
    .first_fail_vld(ff_vld), .first_fail_vec(ff_vec),
    .first_fail_is_sync(ff_sync), .first_fail_bits(ff_bits)
  );

  k4n4_test_checker #(.PASSES(1), .ERR_CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bif(bif2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .vec_idx(vec2),
    .first_fail_vld(ff_vld2), .first_fail_vec(ff_vec2),
    .first_fail_is_sync(ff_sync2), .first_fail_bits(ff_bits2)
  );

  int errors = 0;
  int checks = 0;

  logic [5:0] cflip [8];
  logic [5:0] sflip [8];
  logic       dly2 = 1'b0;
  logic [5:0] s1 = '0;
  logic [5:0] s2 = '0;

  // Gate word from the popcount of the three inputs.
  function automatic logic [5:0] gold(input logic [2:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return {n % 2 == 1, n % 2 == 0, n == 3, n != 3, n > 0, n == 0};
  endfunction

  wire [2:0] abc = {bif.a, bif.b, bif.c};

  assign bif.comb_i  = gold(abc) ^ cflip[abc];
  assign bif.sync_i  = dly2 ? s2 : s1;
  assign bif2.comb_i = '0;
  assign bif2.sync_i = '0;

  always @(posedge clk) begin
    s1 <= gold(abc) ^ sflip[abc];
    s2 <= s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_flips(input int mode);
    for (int v = 0; v < 8; v++) begin
      case (mode)
        0: begin cflip[v] = '0; sflip[v] = '0; end
        1: begin cflip[v] = gold(3'(v)) & 6'h20; sflip[v] = '0; end
        default: begin
          cflip[v] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
          sflip[v] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
        end
      endcase
    end
  endtask

  // Cycle c of a run drives vector c%8; sync seen in cycle c comes
  // from the vector driven one (or two) cycles earlier.
  task automatic ref_run(input logic [2:0] pre, input bit d2,
                         output int n, output bit fv,
                         output logic [2:0] fvec, output bit fs,
                         output logic [5:0] fb);
    n = 0; fv = 0; fvec = '0; fs = 0; fb = '0;
    for (int c = 0; c <= 8 * P; c++) begin
      logic [2:0] v, want_v, src;
      logic [5:0] obs;
      int sc;
      if (c < 8 * P) begin
        v   = 3'(c % 8);
        obs = gold(v) ^ cflip[v];
        if (obs != gold(v)) begin
          n++;
          if (!fv) begin fv = 1; fvec = v; fs = 0; fb = obs; end
        end
      end
      if (c >= 1) begin
        want_v = 3'((c - 1) % 8);
        sc     = d2 ? c - 2 : c - 1;
        src    = (sc < 0) ? pre : 3'(sc % 8);
        obs    = gold(src) ^ sflip[src];
        if (obs != gold(want_v)) begin
          n++;
          if (!fv) begin fv = 1; fvec = want_v; fs = 1; fb = obs; end
        end
      end
    end
  endtask

  task automatic run(input bit d2, input logic [2:0] pre,
                     input int start_at, input int rst_at);
    int n, j;
    bit fv, fs;
    logic [2:0] fvec;
    logic [5:0] fb;
    ref_run(pre, d2, n, fv, fvec, fs, fb);
    dly2 = d2;
    @(negedge clk);
    start = 1'b1;
    j = 0;
    while (j < 200) begin
      @(posedge clk);
      j++;
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (start_at > 0 && j == start_at) start = 1'b1;
      if (start_at > 0 && j == start_at + 1) start = 1'b0;
      if (j - 1 < 8 * P) chk("abc_seq", 32'(abc), 32'((j - 1) % 8));
      if (j == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_abc", 32'(abc), 0);
        chk("rst_vec", 32'(vec_idx), 0);
        return;
      end
      if (done) break;
    end
    chk("run_len", j, 8 * P + 2);
    chk("err_cnt", 32'(err_cnt), n);
    chk("pass", 32'(pass), 32'(n == 0));
    chk("busy_end", 32'(busy), 0);
    chk("abc_end", 32'(abc), 7);
`ifdef K4N4_CHECKER_FIRST_FAIL_EN
    chk("ff_vld", 32'(ff_vld), 32'(fv));
    if (fv) begin
      chk("ff_vec", 32'(ff_vec), 32'(fvec));
      chk("ff_sync", 32'(ff_sync), 32'(fs));
      chk("ff_bits", 32'(ff_bits), 32'(fb));
    end
`else
    chk("ff_tied", {ff_vld, ff_vec, ff_sync, ff_bits}, 0);
`endif
  endtask

  initial begin
    int j;
    bit dropped;
    logic [2:0] last;
    set_flips(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pass", 32'(pass), 0);
    chk("reset_err", 32'(err_cnt), 0);
    chk("reset_abc", 32'(abc), 0);
    chk("reset_ff", {ff_vld, ff_vec, ff_sync, ff_bits}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    run(1'b0, 3'd0, 0, 0);
    set_flips(1);
    run(1'b0, 3'd7, 0, 0);
    chk("xor_stuck16", 32'(err_cnt), 16);
    set_flips(0);
    run(1'b1, 3'd7, 0, 0);
    set_flips(2);
    run(1'b0, 3'd7, 5, 0);
    set_flips(2);
    run(1'b0, 3'd7, 0, 11);
    set_flips(2);
    run(1'b0, 3'd0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      set_flips(2);
      run(1'($urandom_range(0, 1)), 3'd7, 0, 0);
    end

    // Narrow counter fed all-zero words must saturate, never wrap.
    @(negedge clk);
    start2 = 1'b1;
    j = 0;
    dropped = 0;
    last = '0;
    while (j < 50) begin
      @(posedge clk);
      j++;
      @(negedge clk);
      if (j == 1) start2 = 1'b0;
      if (err2 < last) dropped = 1;
      last = err2;
      if (done2) break;
    end
    chk("sat_len", j, 10);
    chk("sat_err", 32'(err2), 7);
    chk("sat_nowrap", 32'(dropped), 0);
    chk("sat_pass", 32'(pass2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
